clk_period_meter: RTL and testbench
===================================

// Module: clk_period_meter
// PURPOSE
//  Measures the period of a slow, asynchronous square wave (e.g. a divided clock) in system-clock cycles.
//  Receive-side counterpart of the clock divider: confirms the divided clock toggles at its programmed rate.
//  Reports each period, flags missing edges (timeout) and asserts lock after stable in-tolerance periods.
// PARAMETERS
//  CNT_W       32     width of period counter and period output
//  EXPECTED    62500  nominal period in clk cycles (2 x divider constant 31250)
//  TOL         16     allowed +/- deviation from EXPECTED for a period to be in range
//  TIMEOUT     131072 cycles without a rising edge before timeout; must be > EXPECTED+TOL
//  LOCK_CNT    4      consecutive in-range periods required to assert locked
//  SYNC_STAGES 2      synchronizer flops on sig_in (>=2)
// PORTS
//  clk           in   1      system clock
//  rst           in   1      reset rst, synchronous, active-high
//  en            in   1      measurement enable
//  sig_in        in   1      asynchronous signal under measurement
//  period        out  CNT_W  last measured period (clk cycles between consecutive rising edges)
//  period_valid  out  1      one-cycle pulse: period updated this cycle
//  in_range      out  1      last period within [EXPECTED-TOL, EXPECTED+TOL]
//  timeout       out  1      sticky: no edge within TIMEOUT; cleared by next period_valid, en low or rst
//  locked        out  1      LOCK_CNT consecutive in-range periods seen
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
//  - sig_in -> SYNC_STAGES flops -> one more flop; rise = sync & ~prev. rise is internal, 1 cycle wide.
//  - FSM: IDLE -> (en) ARM; ARM -> (rise) MEAS, cnt<=1; MEAS: no rise -> cnt<=cnt+1;
//    MEAS rise -> period<=cnt, period_valid<=1, cnt<=1, stay MEAS (back-to-back periods).
//  - Period semantics: rises in cycles t0, t1 -> period = t1-t0. First rise after ARM only starts a measurement.
//  - Latency: period_valid is high in the cycle after rise is high; period/in_range update in that same cycle.
//  - Timeout: in ARM or MEAS, when cycles since entry/last rise reach TIMEOUT with no rise -> timeout<=1,
//    locked<=0, lock counter<=0, state -> ARM, cnt<=0, no period_valid. Rise in the same cycle takes priority.
//  - cnt saturates at all-ones (never wraps); a saturated period is reported as-is (out of range).
//  - Lock: in-range period -> lock_cnt++ (saturate at LOCK_CNT); locked=1 when lock_cnt==LOCK_CNT.
//    Out-of-range period -> lock_cnt<=0, locked<=0. Timeout -> same clear.
//  - en low (any state): next cycle state IDLE, cnt<=0, lock_cnt<=0, locked<=0, timeout<=0, period_valid<=0;
//    period and in_range hold last values. Synchronizer keeps running so en rising does not create a false rise.
//  - en rising: IDLE -> ARM next cycle; first valid period needs two rises seen in ARM/MEAS.
//  - rst mid-measurement: everything returns to reset values next edge, regardless of en/sig_in.
//  - Range compare uses CNT_W+1-bit arithmetic; EXPECTED-TOL clamps at 0.
// STRUCTURE
//  - Shared package clk_meas_pkg: state encoding (IDLE, ARM, MEAS), default EXPECTED/TOL/TIMEOUT constants
//    shared with the clock divider constant.
//  - Sub-module sync_edge_det (SYNC_STAGES param): async input synchronizer + rising-edge pulse; reusable.
//  - Top: FSM, period counter, timeout counter (may share cnt), lock counter, range comparator.
// TESTING  (bench params: EXPECTED=20, TOL=1, TIMEOUT=64, LOCK_CNT=3, SYNC_STAGES=2)
//  - Reset/en: rst high 3 cycles, en=1, sig_in=0 -> all outputs 0; no period_valid for 63 cycles, timeout=1 at 64.
//  - Nominal: sig_in period 20 clks, 5 rises -> 4 period_valid pulses, period=20, in_range=1, locked=1 on 3rd.
//  - Tolerance edges: periods 19, 21, 22 -> in_range 1,1,0; locked drops and lock_cnt resets on 22.
//  - Timeout: after lock, hold sig_in low 70 cycles -> timeout=1, locked=0; next two rises 20 apart -> period=20, timeout=0.
//  - en low mid-measurement: drop en 5 cycles then re-raise -> period holds, locked=0, no period_valid until 2nd rise.
//  - rst during MEAS with sig_in toggling -> outputs 0 next cycle; first period after release is full and correct.

Source files
------------

// File: rtl/clk_meas_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_meas_pkg                                                 |
// | Description : Shared state encoding and default timing constants for the  |
// |               divided-clock period meter and its companion clock divider. |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
package clk_meas_pkg;

  // Meter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } meas_state_e;

  // Divider half-period constant; the divided clock period is twice this
  localparam int unsigned DIV_CONST        = 31250;
  localparam int unsigned DEFAULT_EXPECTED = 2 * DIV_CONST;
  localparam int unsigned DEFAULT_TOL      = 16;
  localparam int unsigned DEFAULT_TIMEOUT  = 131072;
  localparam int unsigned DEFAULT_LOCK_CNT = 4;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_edge_det                                                |
// | Description : Multi-flop synchronizer for an asynchronous input followed  |
// |               by a one-cycle rising-edge pulse on the synchronized value. |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the synchronizer chain and keep one extra
  // delayed copy of the synchronized value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_period_meter                                             |
// | Description : Measures the period of a slow asynchronous square wave in   |
// |               system-clock cycles, flags missing edges and reports lock   |
// |               after consecutive in-tolerance periods.                     |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned EXPECTED    = DEFAULT_EXPECTED,
  parameter int unsigned TOL         = DEFAULT_TOL,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int unsigned LOCK_CNT    = DEFAULT_LOCK_CNT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             timeout,
  output logic             locked
);

  // Counter value at which "TIMEOUT cycles without a rise" is reached on the
  // next edge; a rise on that same edge still wins and is measured normally
  localparam logic [CNT_W-1:0] c_TO_LIMIT   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
  // Range limits one bit wider than the counter so EXPECTED+TOL cannot wrap
  localparam logic [CNT_W:0]   c_RANGE_LO   = (EXPECTED > TOL) ? (CNT_W+1)'(EXPECTED - TOL) : '0;
  localparam logic [CNT_W:0]   c_RANGE_HI   = (CNT_W+1)'(EXPECTED + TOL);
  localparam int unsigned      c_LOCK_W     = $clog2(LOCK_CNT + 1);
  localparam logic [c_LOCK_W-1:0] c_LOCK_MAX = c_LOCK_W'(LOCK_CNT);
  localparam logic [c_LOCK_W-1:0] c_LOCK_ONE = c_LOCK_W'(1);

  meas_state_e         state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [c_LOCK_W-1:0] lock_q;
  logic [CNT_W-1:0]    period_q;
  logic                period_valid_q;
  logic                in_range_q;
  logic                timeout_q;
  logic                locked_q;

  logic                rise;
  logic [CNT_W-1:0]    cnt_inc_d;
  logic [c_LOCK_W-1:0] lock_inc_d;
  logic                in_range_d;
  logic                to_hit_d;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk     (clk),
    .rst     (rst),
    .async_i (sig_in),
    .rise_o  (rise)
  );

  // Saturating increments: the counter never wraps, lock count stops at LOCK_CNT
  assign cnt_inc_d  = (cnt_q == '1) ? cnt_q : cnt_q + c_CNT_ONE;
  assign lock_inc_d = (lock_q == c_LOCK_MAX) ? lock_q : lock_q + c_LOCK_ONE;
  // cnt_q holds the period being closed when a rise arrives in MEAS
  assign in_range_d = ({1'b0, cnt_q} >= c_RANGE_LO) && ({1'b0, cnt_q} <= c_RANGE_HI);
  assign to_hit_d   = (cnt_q >= c_TO_LIMIT);

  // Measurement FSM with shared period/timeout counter and lock tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      lock_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      timeout_q      <= 1'b0;
      locked_q       <= 1'b0;
    end else if (!en) begin
      // Disabled: drop all measurement progress but keep the last result
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      lock_q         <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_ARM;
          cnt_q   <= '0;
        end
        ST_ARM: begin
          if (rise) begin
            // First edge only opens a measurement window
            state_q <= ST_MEAS;
            cnt_q   <= c_CNT_ONE;
          end else if (to_hit_d) begin
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            lock_q    <= '0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            // Close this period and immediately start the next one
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            in_range_q     <= in_range_d;
            timeout_q      <= 1'b0;
            lock_q         <= in_range_d ? lock_inc_d : '0;
            locked_q       <= in_range_d && (lock_inc_d == c_LOCK_MAX);
            cnt_q          <= c_CNT_ONE;
          end else if (to_hit_d) begin
            state_q   <= ST_ARM;
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            lock_q    <= '0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign in_range     = in_range_q;
  assign timeout      = timeout_q;
  assign locked       = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clk_period_meter                                          |
// | Description : Self-checking bench for clk_period_meter: directed scenarios |
// |               plus random periods, gaps, enable drops and resets, checked |
// |               every cycle against a timestamp-based reference model.      |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module tb_clk_period_meter;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned EXPECTED    = 20;
  localparam int unsigned TOL         = 1;
  localparam int unsigned TIMEOUT     = 64;
  localparam int unsigned LOCK_CNT    = 3;
  localparam int unsigned SYNC_STAGES = 2;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             en     = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             in_range;
  logic             timeout;
  logic             locked;

  clk_period_meter #(
    .CNT_W       (CNT_W),
    .EXPECTED    (EXPECTED),
    .TOL         (TOL),
    .TIMEOUT     (TIMEOUT),
    .LOCK_CNT    (LOCK_CNT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range),
    .timeout      (timeout),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_cnt   = 0;

  // Reference model: sig_in values sampled at past edges, plus timestamps
  bit               hist [0:SYNC_STAGES];
  longint           edge_no   = 0;
  bit               m_active  = 1'b0;   // enabled and watching for edges
  bit               m_started = 1'b0;   // a reference rise has been seen
  longint           m_base    = 0;      // cycles since reference = edge_no - m_base
  logic [CNT_W-1:0] m_period  = '0;
  bit               m_pv      = 1'b0;
  bit               m_inr     = 1'b0;
  bit               m_to      = 1'b0;
  bit               m_locked  = 1'b0;
  int               m_run     = 0;      // consecutive in-range periods

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // Advance the model by one clock edge using the inputs present before it
  task automatic model_edge(input bit r, input bit e, input bit s);
    bit     rise;
    longint p;
    edge_no++;
    // The internal edge pulse sees sig_in as sampled SYNC_STAGES and
    // SYNC_STAGES+1 edges ago
    rise = hist[SYNC_STAGES-1] && !hist[SYNC_STAGES];
    if (r) begin
      for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 1'b0;
    end else begin
      for (int i = SYNC_STAGES; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = s;
    end

    if (r) begin
      m_active = 0; m_started = 0; m_period = '0; m_pv = 0;
      m_inr = 0; m_to = 0; m_locked = 0; m_run = 0;
    end else if (!e) begin
      m_active = 0; m_started = 0; m_pv = 0; m_to = 0; m_locked = 0; m_run = 0;
    end else if (!m_active) begin
      m_active = 1; m_started = 0; m_pv = 0;
      m_base = edge_no + 1;
    end else begin
      m_pv = 0;
      if (rise) begin
        if (m_started) begin
          p        = edge_no - m_base;
          m_period = CNT_W'(p);
          m_pv     = 1;
          m_to     = 0;
          m_inr    = (p >= longint'(EXPECTED) - longint'(TOL)) &&
                     (p <= longint'(EXPECTED) + longint'(TOL));
          m_run    = m_inr ? ((m_run < LOCK_CNT) ? m_run + 1 : m_run) : 0;
          m_locked = (m_run == LOCK_CNT);
        end
        m_started = 1;
        m_base    = edge_no;
      end else if (edge_no - m_base >= longint'(TIMEOUT) - 1) begin
        m_to = 1; m_locked = 0; m_run = 0; m_started = 0;
        m_base = edge_no + 1;
      end
    end
  endtask

  // One clock: update the model at the edge, then compare all outputs
  task automatic tick();
    @(posedge clk);
    model_edge(rst, en, sig_in);
    #1;
    if (period_valid) pv_cnt++;
    check_eq("period",       period,       m_period);
    check_eq("period_valid", period_valid, m_pv);
    check_eq("in_range",     in_range,     m_inr);
    check_eq("timeout",      timeout,      m_to);
    check_eq("locked",       locked,       m_locked);
  endtask

  task automatic hold(input logic s, input int n);
    sig_in = s;
    repeat (n) tick();
  endtask

  // One square-wave period starting with a rising edge
  task automatic wave(input int p);
    hold(1'b1, p / 2);
    hold(1'b0, p - p / 2);
  endtask

  initial begin
    for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 1'b0;

    // Reset with enable high and a quiet input
    rst = 1'b1; en = 1'b1; sig_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    pv_cnt = 0;
    hold(1'b0, 63);
    check_eq("rst_no_pv", pv_cnt, 0);
    check_eq("rst_no_early_to", timeout, 0);
    hold(1'b0, 7);
    check_eq("rst_timeout", timeout, 1);

    // Nominal train: 5 rises give 4 periods and lock
    pv_cnt = 0;
    repeat (5) wave(20);
    check_eq("nom_pulses", pv_cnt, 4);
    check_eq("nom_period", period, 20);
    check_eq("nom_locked", locked, 1);
    check_eq("nom_to_clear", timeout, 0);

    // Tolerance boundaries 19 / 21 in range, 22 out
    wave(19); wave(21); wave(22); wave(20);
    check_eq("tol_period22", period, 22);
    check_eq("tol_inrange22", in_range, 0);
    check_eq("tol_unlock", locked, 0);

    // Missing edges after lock
    repeat (4) wave(20);
    check_eq("to_prelock", locked, 1);
    hold(1'b0, 70);
    check_eq("to_flag", timeout, 1);
    check_eq("to_unlock", locked, 0);
    wave(20); wave(20);
    check_eq("to_period", period, 20);
    check_eq("to_cleared", timeout, 0);

    // Enable dropped mid-measurement
    repeat (4) wave(20);
    hold(1'b1, 10);
    en = 1'b0;
    hold(1'b0, 5);
    en = 1'b1;
    check_eq("en_period_hold", period, 20);
    check_eq("en_unlock", locked, 0);
    hold(1'b0, 5);
    pv_cnt = 0;
    wave(20);
    check_eq("en_first_rise_no_pv", pv_cnt, 0);
    wave(20);
    check_eq("en_second_rise_pv", pv_cnt, 1);

    // Reset while measuring
    wave(20);
    hold(1'b1, 5);
    sig_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstm_period", period, 0);
    hold(1'b0, 5);
    pv_cnt = 0;
    wave(20); wave(20);
    check_eq("rstm_pulses", pv_cnt, 1);
    check_eq("rstm_period_full", period, 20);

    // Random mix of periods, gaps, enable drops and resets
    for (int it = 0; it < 80; it++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        en = 1'b0;
        hold(sig_in, int'($urandom_range(1, 6)));
        en = 1'b1;
      end else if (sel == 1) begin
        hold(1'b0, int'($urandom_range(50, 80)));
      end else if (sel == 2) begin
        rst = 1'b1;
        hold(sig_in, int'($urandom_range(1, 2)));
        rst = 1'b0;
      end else begin
        wave(int'($urandom_range(16, 25)));
      end
    end
    hold(1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
